// File: rtl/dvi_timing_gen.sv
// Raster timing generator: pixel/line/frame counters with registered
// sync, data-enable and border decode for the DVI test-pattern path.
module dvi_timing_gen #(
    parameter int unsigned H_ACTIVE  = 1024,
    parameter int unsigned H_FP      = 24,
    parameter int unsigned H_SYNC    = 136,
    parameter int unsigned H_BP      = 160,
    parameter int unsigned V_ACTIVE  = 768,
    parameter int unsigned V_FP      = 3,
    parameter int unsigned V_SYNC    = 6,
    parameter int unsigned V_BP      = 29,
    parameter logic        HS_POL    = 1'b0,
    parameter logic        VS_POL    = 1'b0,
    parameter logic        BORDER_EN = 1'b1
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        EN,
    output logic [10:0] X,
    output logic [9:0]  Y,
    output logic [10:0] frame,
    output logic        MASK,
    output logic        LIGHT,
    output logic        DE,
    output logic        HSYNC,
    output logic        VSYNC,
    output logic        SOF
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [10:0] H_LAST = 11'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);

    // Thresholds carry one extra bit so a sync pulse ending exactly at
    // the 2048/1024 limit does not alias to zero.
    localparam logic [11:0] H_ACT    = 12'(H_ACTIVE);
    localparam logic [11:0] H_ACT_LS = 12'(H_ACTIVE - 1);
    localparam logic [11:0] HS_BEG   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
    localparam logic [10:0] V_ACT_LS = 11'(V_ACTIVE - 1);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] x_q, x_d;
    logic [9:0]  y_q, y_d;
    logic [10:0] frame_q, frame_d;
    logic        de_q, de_d;
    logic        mask_q, mask_d;
    logic        light_q, light_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        sof_q, sof_d;

    logic        h_wrap;
    logic        v_wrap;
    logic [11:0] xe;
    logic [10:0] ye;
    logic        h_act;
    logic        v_act;
    logic        active;
    logic        edge_px;
    logic        border;

    // Next pixel position; decode is applied to it so every output flop
    // describes the same presented pixel.
    always_comb begin
        h_wrap  = (x_q >= H_LAST);
        v_wrap  = (y_q >= V_LAST);
        x_d     = h_wrap ? 11'd0 : x_q + 11'd1;
        y_d     = y_q;
        frame_d = frame_q;
        if (h_wrap) begin
            y_d = v_wrap ? 10'd0 : y_q + 10'd1;
            if (v_wrap) begin
                frame_d = frame_q + 11'd1;
            end
        end
    end

    always_comb begin
        xe      = {1'b0, x_d};
        ye      = {1'b0, y_d};
        h_act   = (xe < H_ACT);
        v_act   = (ye < V_ACT);
        active  = h_act && v_act;
        edge_px = (xe == 12'd0) || (xe == H_ACT_LS) ||
                  (ye == 11'd0) || (ye == V_ACT_LS);
        border  = BORDER_EN && active && edge_px;
        de_d    = active;
        mask_d  = !active || border;
        light_d = border;
        hs_d    = ((xe >= HS_BEG) && (xe < HS_END)) ? HS_POL : !HS_POL;
        vs_d    = ((ye >= VS_BEG) && (ye < VS_END)) ? VS_POL : !VS_POL;
        sof_d   = (x_d == 11'd0) && (y_d == 10'd0);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            x_q     <= H_LAST;
            y_q     <= V_LAST;
            frame_q <= 11'h7FF;
            de_q    <= 1'b0;
            mask_q  <= 1'b1;
            light_q <= 1'b0;
            hs_q    <= !HS_POL;
            vs_q    <= !VS_POL;
            sof_q   <= 1'b0;
        end else if (EN) begin
            x_q     <= x_d;
            y_q     <= y_d;
            frame_q <= frame_d;
            de_q    <= de_d;
            mask_q  <= mask_d;
            light_q <= light_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            sof_q   <= sof_d;
        end
    end

    assign X     = x_q;
    assign Y     = y_q;
    assign frame = frame_q;
    assign DE    = de_q;
    assign MASK  = mask_q;
    assign LIGHT = light_q;
    assign HSYNC = hs_q;
    assign VSYNC = vs_q;
    assign SOF   = sof_q;

endmodule

// File: tb/tb_dvi_timing_gen.sv
// Bench for dvi_timing_gen: default, mid-size and tiny rasters checked
// against an arithmetic pixel-index model under random EN.
module tb_dvi_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a = 1'b0, en_a = 1'b0;
    logic rst_b = 1'b0, en_b = 1'b0;
    logic rst_c = 1'b0, en_c = 1'b0;

    logic [10:0] X_a, X_b, X_c, F_a, F_b, F_c;
    logic [9:0]  Y_a, Y_b, Y_c;
    logic MK_a, LT_a, DE_a, HS_a, VS_a, SOF_a;
    logic MK_b, LT_b, DE_b, HS_b, VS_b, SOF_b;
    logic MK_c, LT_c, DE_c, HS_c, VS_c, SOF_c;

    dvi_timing_gen #(
        .H_ACTIVE(1024), .H_FP(24), .H_SYNC(136), .H_BP(160),
        .V_ACTIVE(768), .V_FP(3), .V_SYNC(6), .V_BP(29),
        .HS_POL(1'b0), .VS_POL(1'b0), .BORDER_EN(1'b1)
    ) u_a (
        .CLK(clk), .RST_N(rst_a), .EN(en_a), .X(X_a), .Y(Y_a),
        .frame(F_a), .MASK(MK_a), .LIGHT(LT_a), .DE(DE_a),
        .HSYNC(HS_a), .VSYNC(VS_a), .SOF(SOF_a)
    );

    dvi_timing_gen #(
        .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
        .HS_POL(1'b1), .VS_POL(1'b1), .BORDER_EN(1'b0)
    ) u_b (
        .CLK(clk), .RST_N(rst_b), .EN(en_b), .X(X_b), .Y(Y_b),
        .frame(F_b), .MASK(MK_b), .LIGHT(LT_b), .DE(DE_b),
        .HSYNC(HS_b), .VSYNC(VS_b), .SOF(SOF_b)
    );

    dvi_timing_gen #(
        .H_ACTIVE(2), .H_FP(1), .H_SYNC(1), .H_BP(1),
        .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
        .HS_POL(1'b0), .VS_POL(1'b0), .BORDER_EN(1'b1)
    ) u_c (
        .CLK(clk), .RST_N(rst_c), .EN(en_c), .X(X_c), .Y(Y_c),
        .frame(F_c), .MASK(MK_c), .LIGHT(LT_c), .DE(DE_c),
        .HSYNC(HS_c), .VSYNC(VS_c), .SOF(SOF_c)
    );

    logic [37:0] obs_a, obs_b, obs_c;
    assign obs_a = {X_a, Y_a, F_a, DE_a, MK_a, LT_a, HS_a, VS_a, SOF_a};
    assign obs_b = {X_b, Y_b, F_b, DE_b, MK_b, LT_b, HS_b, VS_b, SOF_b};
    assign obs_c = {X_c, Y_c, F_c, DE_c, MK_c, LT_c, HS_c, VS_c, SOF_c};

    int vectors = 0;
    int miscompares = 0;
    longint adv_a = 0, adv_b = 0, adv_c = 0;

    // adv = enabled advances since reset; adv 0 is the frame's last pixel
    function automatic logic [37:0] model(
        input int ha, input int hf, input int hs, input int hb,
        input int va, input int vf, input int vs, input int vb,
        input bit hp, input bit vp, input bit be, input longint adv);
        longint ht, vt, fp, c, pix;
        int x, y, f;
        bit act, bor, hsy, vsy, sof;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        fp = ht * vt;
        c = adv - 1 + fp * 2048;
        pix = c % fp;
        f = int'((c / fp) % 2048);
        x = int'(pix % ht);
        y = int'(pix / ht);
        act = (x < ha) && (y < va);
        bor = be && act && (x == 0 || x == ha - 1 || y == 0 || y == va - 1);
        hsy = (x >= ha + hf && x < ha + hf + hs) ? hp : !hp;
        vsy = (y >= va + vf && y < va + vf + vs) ? vp : !vp;
        sof = (x == 0) && (y == 0);
        return {11'(x), 10'(y), 11'(f), act, !act || bor, bor, hsy, vsy, sof};
    endfunction

    function automatic logic [37:0] exp_a();
        return model(1024, 24, 136, 160, 768, 3, 6, 29, 0, 0, 1, adv_a);
    endfunction
    function automatic logic [37:0] exp_b();
        return model(16, 2, 3, 3, 12, 2, 3, 3, 1, 1, 0, adv_b);
    endfunction
    function automatic logic [37:0] exp_c();
        return model(2, 1, 1, 1, 2, 1, 1, 1, 0, 0, 1, adv_c);
    endfunction

    task automatic tick_a(input bit r, input bit e);
        rst_a = r; en_a = e;
        @(posedge clk); #1;
        if (!r) adv_a = 0;
        else if (e) adv_a++;
    endtask
    task automatic tick_b(input bit r, input bit e);
        rst_b = r; en_b = e;
        @(posedge clk); #1;
        if (!r) adv_b = 0;
        else if (e) adv_b++;
    endtask
    task automatic tick_c(input bit r, input bit e);
        rst_c = r; en_c = e;
        @(posedge clk); #1;
        if (!r) adv_c = 0;
        else if (e) adv_c++;
    endtask

    localparam logic [37:0] RST_A =
        {11'd1343, 10'd805, 11'd2047, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    localparam logic [37:0] FIRST_A =
        {11'd0, 10'd0, 11'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            tick_a(1'b0, 1'(i % 2));
            vectors++;
            if (obs_a !== RST_A) begin
                miscompares++;
                $display("FAIL reset_a cyc%0d got %h exp %h", i, obs_a, RST_A);
            end
            vectors++;
            if (obs_a !== exp_a()) begin
                miscompares++;
                $display("FAIL reset_model cyc%0d got %h exp %h", i, obs_a, exp_a());
            end
        end
        tick_a(1'b1, 1'b0);
        vectors++;
        if (obs_a !== RST_A) begin
            miscompares++;
            $display("FAIL release_hold got %h exp %h", obs_a, RST_A);
        end
        tick_a(1'b1, 1'b1);
        vectors++;
        if (obs_a !== FIRST_A) begin
            miscompares++;
            $display("FAIL first_pixel got %h exp %h", obs_a, FIRST_A);
        end
    endtask

    task automatic test_line_wrap();
        logic [37:0] e;
        while (adv_a < 1345) begin
            tick_a(1'b1, $urandom_range(0, 7) != 0);
            e = exp_a();
            vectors++;
            if (obs_a !== e) begin
                miscompares++;
                $display("FAIL line_a adv%0d got %h exp %h", adv_a, obs_a, e);
            end
            case (adv_a)
                1024: begin
                    vectors++;
                    if ({X_a, DE_a, MK_a, LT_a} !== {11'd1023, 3'b111}) begin
                        miscompares++;
                        $display("FAIL x1023 got %b exp 111", {DE_a, MK_a, LT_a});
                    end
                end
                1025: begin
                    vectors++;
                    if ({X_a, DE_a, MK_a, LT_a} !== {11'd1024, 3'b010}) begin
                        miscompares++;
                        $display("FAIL x1024 got %b exp 010", {DE_a, MK_a, LT_a});
                    end
                end
                1048, 1185: begin
                    vectors++;
                    if (HS_a !== 1'b1) begin
                        miscompares++;
                        $display("FAIL hs_off x%0d got %b exp 1", X_a, HS_a);
                    end
                end
                1049, 1184: begin
                    vectors++;
                    if (HS_a !== 1'b0) begin
                        miscompares++;
                        $display("FAIL hs_on x%0d got %b exp 0", X_a, HS_a);
                    end
                end
                1345: begin
                    vectors++;
                    if ({X_a, Y_a} !== {11'd0, 10'd1}) begin
                        miscompares++;
                        $display("FAIL wrap got %0d,%0d exp 0,1", X_a, Y_a);
                    end
                end
                default: ;
            endcase
        end
    endtask

    task automatic test_interior_stall_reset();
        logic [37:0] e, saved;
        while (adv_a < 10 * 1344 + 501) begin
            tick_a(1'b1, $urandom_range(0, 7) != 0);
            e = exp_a();
            vectors++;
            if (obs_a !== e) begin
                miscompares++;
                $display("FAIL run_a adv%0d got %h exp %h", adv_a, obs_a, e);
            end
        end
        vectors++;
        if ({X_a, Y_a, DE_a, MK_a, LT_a} !== {11'd500, 10'd10, 3'b100}) begin
            miscompares++;
            $display("FAIL interior got %0d,%0d %b exp 500,10 100",
                     X_a, Y_a, {DE_a, MK_a, LT_a});
        end
        while (adv_a < 10 * 1344 + 1343) begin
            tick_a(1'b1, $urandom_range(0, 7) != 0);
            e = exp_a();
            vectors++;
            if (obs_a !== e) begin
                miscompares++;
                $display("FAIL run2_a adv%0d got %h exp %h", adv_a, obs_a, e);
            end
        end
        saved = obs_a;
        for (int i = 0; i < 5; i++) begin
            tick_a(1'b1, 1'b0);
            vectors++;
            if (obs_a !== saved || obs_a !== exp_a()) begin
                miscompares++;
                $display("FAIL stall cyc%0d got %h exp %h", i, obs_a, saved);
            end
        end
        tick_a(1'b1, 1'b1);
        vectors++;
        if ({X_a, Y_a} !== {11'd1343, 10'd10}) begin
            miscompares++;
            $display("FAIL resume1 got %0d,%0d exp 1343,10", X_a, Y_a);
        end
        tick_a(1'b1, 1'b1);
        vectors++;
        if ({X_a, Y_a} !== {11'd0, 10'd11}) begin
            miscompares++;
            $display("FAIL resume2 got %0d,%0d exp 0,11", X_a, Y_a);
        end
        tick_a(1'b0, 1'b1);
        vectors++;
        if (obs_a !== RST_A) begin
            miscompares++;
            $display("FAIL midreset got %h exp %h", obs_a, RST_A);
        end
        tick_a(1'b1, 1'b1);
        vectors++;
        if (obs_a !== FIRST_A) begin
            miscompares++;
            $display("FAIL midrelease got %h exp %h", obs_a, FIRST_A);
        end
        en_a = 1'b0;
    endtask

    task automatic test_vertical_b();
        logic [37:0] e;
        logic [37:0] rst_b_exp;
        longint stop;
        rst_b_exp = {11'd23, 10'd19, 11'd2047, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tick_b(1'b0, 1'b1);
        tick_b(1'b0, 1'b0);
        vectors++;
        if (obs_b !== rst_b_exp) begin
            miscompares++;
            $display("FAIL reset_b got %h exp %h", obs_b, rst_b_exp);
        end
        while (adv_b < 2 * 480 + 50) begin
            tick_b(1'b1, $urandom_range(0, 3) != 0);
            e = exp_b();
            vectors++;
            if (obs_b !== e) begin
                miscompares++;
                $display("FAIL run_b adv%0d got %h exp %h", adv_b, obs_b, e);
            end
            case (adv_b)
                1: begin
                    vectors++;
                    if ({DE_b, MK_b, LT_b, SOF_b} !== 4'b1001) begin
                        miscompares++;
                        $display("FAIL noborder got %b exp 1001",
                                 {DE_b, MK_b, LT_b, SOF_b});
                    end
                end
                336, 409: begin
                    vectors++;
                    if (VS_b !== 1'b0) begin
                        miscompares++;
                        $display("FAIL vs_off adv%0d got %b exp 0", adv_b, VS_b);
                    end
                end
                337, 408: begin
                    vectors++;
                    if (VS_b !== 1'b1) begin
                        miscompares++;
                        $display("FAIL vs_on adv%0d got %b exp 1", adv_b, VS_b);
                    end
                end
                481: begin
                    vectors++;
                    if ({F_b, SOF_b} !== {11'd1, 1'b1}) begin
                        miscompares++;
                        $display("FAIL frame_inc got %0d sof %b exp 1 1", F_b, SOF_b);
                    end
                end
                default: ;
            endcase
        end
        stop = adv_b + longint'($urandom_range(1, 400));
        while (adv_b < stop) tick_b(1'b1, 1'b1);
        tick_b(1'b0, 1'b1);
        vectors++;
        if (obs_b !== rst_b_exp) begin
            miscompares++;
            $display("FAIL midreset_b got %h exp %h", obs_b, rst_b_exp);
        end
        tick_b(1'b1, 1'b1);
        vectors++;
        if ({X_b, Y_b, F_b, SOF_b} !== 33'd1 || obs_b !== exp_b()) begin
            miscompares++;
            $display("FAIL midrelease_b got %h exp %h", obs_b, exp_b());
        end
        en_b = 1'b0;
    endtask

    task automatic test_frame_wrap_c();
        logic [37:0] e;
        logic [37:0] rst_c_exp;
        rst_c_exp = {11'd4, 10'd4, 11'd2047, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        tick_c(1'b0, 1'b1);
        vectors++;
        if (obs_c !== rst_c_exp) begin
            miscompares++;
            $display("FAIL reset_c got %h exp %h", obs_c, rst_c_exp);
        end
        while (adv_c < 2048 * 25 + 1) begin
            tick_c(1'b1, 1'b1);
            e = exp_c();
            vectors++;
            if (obs_c !== e) begin
                miscompares++;
                $display("FAIL run_c adv%0d got %h exp %h", adv_c, obs_c, e);
            end
            if (adv_c == 2048 * 25) begin
                vectors++;
                if ({X_c, Y_c, F_c} !== {11'd4, 10'd4, 11'd2047}) begin
                    miscompares++;
                    $display("FAIL frame2047 got %0d exp 2047", F_c);
                end
            end
        end
        vectors++;
        if ({X_c, Y_c, F_c, SOF_c} !== {11'd0, 10'd0, 11'd0, 1'b1}) begin
            miscompares++;
            $display("FAIL frame_wrap got %0d sof %b exp 0 1", F_c, SOF_c);
        end
        en_c = 1'b0;
    endtask

    initial begin
        test_reset();
        test_line_wrap();
        test_interior_stall_reset();
        test_vertical_b();
        test_frame_wrap_c();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
